// File: rtl/spi_pkg.sv
// Shared constants and the FSM state type for the SPI responder.
package spi_pkg;

  localparam int SPI_DATA_W_DEF      = 8;
  localparam int SPI_SYNC_STAGES_DEF = 2;

  // Frame FSM: wait for CS, shift a frame, then wait for CS to drop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus one delay flop for edge detection on a
// signal that is asynchronous to clk.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES = SPI_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Synchronizer chain; the delay flop holds the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~dly_q;
  assign fall_o  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: CS active-high, SCK idles low, MSB first, MOSI sampled on
// SCK rise, MISO updated on SCK fall. All SPI pins are oversampled by clk.
//
// TX handshake: a word transfers on a clk edge where tx_valid && tx_ready.
// tx_ready is high exactly when the one-word holding register is empty; a
// tx_valid seen while tx_ready is low is ignored and never overwrites it.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEF,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .async_i(sck),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_i(cs),
    .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // MOSI goes through the same depth so it stays aligned with the SCK edges.
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .async_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              tx_full_q, tx_full_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              underrun_q, underrun_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_rx_q  <= '0;
      shift_tx_q  <= '0;
      tx_buf_q    <= '0;
      rx_data_q   <= '0;
      tx_full_q   <= 1'b0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_rx_q  <= shift_rx_d;
      shift_tx_q  <= shift_tx_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      tx_full_q   <= tx_full_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next-state: frame FSM, shifters and TX holding register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_rx_d  = shift_rx_q;
    shift_tx_d  = shift_tx_q;
    tx_buf_d    = tx_buf_q;
    rx_data_d   = rx_data_q;
    tx_full_d   = tx_full_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          if (tx_full_q) begin
            shift_tx_d = tx_buf_q;
            tx_full_d  = 1'b0;
            miso_d     = tx_buf_q[DATA_W-1];
          end else begin
            shift_tx_d = '0;
            underrun_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (sck_rise && bit_cnt_q == CNT_LAST) begin
          // Final bit wins over a simultaneous CS drop: the frame is complete.
          shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
          rx_data_d  = {shift_rx_q[DATA_W-2:0], mosi_s};
          rx_valid_d = 1'b1;
          bit_cnt_d  = CNT_FULL;
          if (cs_fall) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end else if (cs_fall) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (sck_rise) begin
          shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end else if (sck_fall && bit_cnt_q != '0 && bit_cnt_q < CNT_FULL) begin
          shift_tx_d = shift_tx_q << 1;
          miso_d     = shift_tx_q[DATA_W-2];
        end
      end

      ST_DONE: begin
        if (cs_fall) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // Accept only into an empty buffer; a load above needs it full, so the
    // two never collide and a same-cycle accept serves the following frame.
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = ~tx_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a master driver, a TX/RX reference model with an
// expected-word queue, a constant vector table, hand sequences and random frames.
module tb_spi_slave;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;   // SCK half period in clk cycles (SCK = clk/8)

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck = 1'b0;
  logic              cs = 1'b0;
  logic              mosi = 1'b0;
  logic              miso;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              frame_err;
  logic              underrun;

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .underrun(underrun)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: words the DUT should report, words waiting to be sent.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] tx_model[$];
  logic [DATA_W-1:0] last_rx = '0;

  // Pulse counters on the DUT status strobes.
  int rx_cnt = 0, ferr_cnt = 0, und_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid)  rx_cnt   <= rx_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (underrun)  und_cnt  <= und_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one TX word and wait (bounded) for the handshake.
  task automatic tx_push(input logic [DATA_W-1:0] w);
    bit ok = 1'b0;
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (tx_ready) ok = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("tx_accept", {31'd0, ok}, 32'd1);
    if (ok) tx_model.push_back(w);
  endtask

  // Master side of one frame of nbits SCK cycles; collects what it observes.
  task automatic send_frame(input logic [DATA_W-1:0] word, input int nbits,
                            output logic [DATA_W-1:0] miso_word,
                            output logic [DATA_W-1:0] rx_seen, output int lat,
                            output logic busy_seen, output int d_rx,
                            output int d_err, output int d_und);
    int rx0, e0, u0;
    @(negedge clk);
    rx0 = rx_cnt; e0 = ferr_cnt; u0 = und_cnt;
    miso_word = '0; rx_seen = '0; lat = -1;
    cs   = 1'b1;
    mosi = word[DATA_W-1];
    repeat (HALF) @(negedge clk);
    busy_seen = busy;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[DATA_W-1-i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      miso_word = {miso_word[DATA_W-2:0], miso};
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (i == nbits - 1 && lat < 0 && rx_valid) begin
          lat     = k;
          rx_seen = rx_data;
        end
      end
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs   = 1'b0;
    mosi = 1'b0;
    repeat (HALF + 2) @(negedge clk);
    d_rx  = rx_cnt - rx0;
    d_err = ferr_cnt - e0;
    d_und = und_cnt - u0;
  endtask

  // One frame checked against the reference model.
  task automatic model_frame(input logic [DATA_W-1:0] word, input int nbits,
                             output logic [DATA_W-1:0] miso_word,
                             output int d_err, output int d_und);
    logic [DATA_W-1:0] exp_miso, rx_seen;
    logic              exp_und, busy_seen;
    int                lat, d_rx;
    exp_und  = (tx_model.size() == 0);
    exp_miso = exp_und ? '0 : tx_model.pop_front();
    if (nbits == DATA_W) exp_q.push_back(word);
    send_frame(word, nbits, miso_word, rx_seen, lat, busy_seen, d_rx, d_err, d_und);
    check("busy_in_frame", {31'd0, busy_seen}, 32'd1);
    check("underrun_pulses", d_und, {31'd0, exp_und});
    if (nbits == DATA_W) begin
      check("rx_pulses", d_rx, 1);
      check("frame_err_pulses", d_err, 0);
      check("rx_latency", lat, SYNC_STAGES + 1);
      check("rx_word", {24'd0, rx_seen}, {24'd0, exp_q.pop_front()});
      check("miso_word", {24'd0, miso_word}, {24'd0, exp_miso});
      last_rx = word;
    end else begin
      check("rx_pulses_short", d_rx, 0);
      check("frame_err_short", d_err, 1);
    end
    check("rx_data_held", {24'd0, rx_data}, {24'd0, last_rx});
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    bit                load;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] mosi_w;
    int                nbits;
    logic [DATA_W-1:0] exp_miso;
    logic [DATA_W-1:0] exp_rx_data;
    int                exp_und;
    int                exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [DATA_W-1:0] mw, mw2;
    int de, du;

    vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8, 8'h3C, 8'hA5, 0, 0};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8, 8'h00, 8'hFF, 1, 0};
    vecs[2] = '{1'b1, 8'h77, 8'h96, 5, 8'h00, 8'hFF, 0, 1};
    vecs[3] = '{1'b1, 8'h81, 8'h00, 8, 8'h81, 8'h00, 0, 0};
    vecs[4] = '{1'b0, 8'h00, 8'h7E, 1, 8'h00, 8'h00, 1, 1};

    // Reset.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_underrun", {31'd0, underrun}, 32'd0);
    check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);

    // Vector table.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].load) tx_push(vecs[v].tx);
      model_frame(vecs[v].mosi_w, vecs[v].nbits, mw, de, du);
      if (vecs[v].nbits == DATA_W)
        check("vec_miso", {24'd0, mw}, {24'd0, vecs[v].exp_miso});
      check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[v].exp_rx_data});
      check("vec_underrun", du, vecs[v].exp_und);
      check("vec_frame_err", de, vecs[v].exp_err);
    end

    // Back-to-back frames, second TX word written mid-frame.
    tx_push(8'hAA);
    fork
      model_frame(8'h01, DATA_W, mw, de, du);
      begin
        repeat (30) @(negedge clk);
        tx_push(8'h55);
      end
    join
    model_frame(8'h80, DATA_W, mw2, de, du);
    check("b2b_miso_1", {24'd0, mw}, 32'hAA);
    check("b2b_miso_2", {24'd0, mw2}, 32'h55);

    // tx_valid while full is ignored.
    tx_push(8'h11);
    @(negedge clk);
    tx_data  = 8'h22;
    tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tx_ready_while_full", {31'd0, tx_ready}, 32'd0);
    end
    tx_valid = 1'b0;
    model_frame(8'h3D, DATA_W, mw, de, du);
    check("full_hold_miso", {24'd0, mw}, 32'h11);
    check("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
    model_frame(8'hC4, DATA_W, mw, de, du);
    check("full_hold_underrun", du, 1);

    // Reset mid-frame at bit 4 with a TX word pending.
    @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    tx_push(8'h33);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    cs    = 1'b0;
    sck   = 1'b0;
    mosi  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tx_model.delete();
    last_rx = '0;
    check("midrst_miso", {31'd0, miso}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_underrun", {31'd0, underrun}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    repeat (4) @(negedge clk);
    model_frame(8'h5A, DATA_W, mw, de, du);
    check("post_rst_rx", {24'd0, rx_data}, 32'h5A);

    // Random frames against the model.
    for (int r = 0; r < 30; r++) begin
      int nb;
      if ($urandom_range(0, 1) == 1 && tx_model.size() == 0)
        tx_push(DATA_W'($urandom_range(0, 255)));
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DATA_W - 1)) : DATA_W;
      model_frame(DATA_W'($urandom_range(0, 255)), nb, mw, de, du);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
